// File: rtl/imem_pkg.sv
// Shared constants and loader state type for the PC / instruction memory / loader slice.
package imem_pkg;

    localparam int IMEM_ADDR_W = 8;
    localparam int IMEM_DATA_W = 24;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_WRITE   = 2'd2,
        ST_DONE    = 2'd3
    } loader_state_t;

endpackage

// File: rtl/imem_byte_assembler.sv
// Big-endian byte-to-word shift register with a byte index.
// word_full flags the accepted byte that completes the current word.
module imem_byte_assembler
    import imem_pkg::*;
#(
    parameter int DATA_W = IMEM_DATA_W
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              clear,
    input  logic              shift,
    input  logic [7:0]        byte_in,
    output logic [DATA_W-1:0] word,
    output logic              word_full
);

    localparam int NBYTES = DATA_W / 8;
    localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    logic [IDX_W-1:0] byte_idx;

    assign word_full = shift && !clear && (byte_idx == LAST_IDX);

    // Earlier bytes migrate toward the MSBs, so the first byte ends up on top.
    always_ff @(posedge CLK) begin
        if (!reset) begin
            byte_idx <= '0;
            word     <= '0;
        end else if (clear) begin
            byte_idx <= '0;
        end else if (shift) begin
            word     <= (word << 8) | DATA_W'(byte_in);
            byte_idx <= word_full ? '0 : byte_idx + IDX_W'(1);
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Loads program bytes into instruction memory as DATA_W-bit words from base_addr onward.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | waiting for start; byte index held at zero
// ST_COLLECT | accepting bytes until a full word is assembled
// ST_WRITE   | one-cycle memory write, then next word or finish
// ST_DONE    | one-cycle done pulse (normal end or abort)
module imem_loader
    import imem_pkg::*;
#(
    parameter int ADDR_W = IMEM_ADDR_W,
    parameter int DATA_W = IMEM_DATA_W
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] word_count,
    input  logic              abort,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              done
);

    // One extra bit so a word_count of zero can stand for the full 2^ADDR_W words.
    localparam int CNT_W = ADDR_W + 1;

    loader_state_t    state, state_next;
    logic [CNT_W-1:0] remaining;
    logic             accept;
    logic             asm_clear;
    logic             word_full;
    logic             last_word;

    assign accept    = byte_valid && byte_ready && !abort;
    assign asm_clear = (state == ST_IDLE) || ((state == ST_COLLECT) && abort);
    assign last_word = (remaining == CNT_W'(1));

    imem_byte_assembler #(
        .DATA_W (DATA_W)
    ) u_assembler (
        .CLK       (CLK),
        .reset     (reset),
        .clear     (asm_clear),
        .shift     (accept),
        .byte_in   (byte_in),
        .word      (wr_data),
        .word_full (word_full)
    );

    always_ff @(posedge CLK) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:    if (start) state_next = ST_COLLECT;
            ST_COLLECT: begin
                if (abort)          state_next = ST_DONE;
                else if (word_full) state_next = ST_WRITE;
            end
            ST_WRITE:   state_next = (abort || last_word) ? ST_DONE : ST_COLLECT;
            ST_DONE:    state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        byte_ready = (state == ST_COLLECT);
        wr_en      = (state == ST_WRITE) && !abort;
        busy       = (state == ST_COLLECT) || (state == ST_WRITE);
        done       = (state == ST_DONE);
    end

    // Down-counter of words still to write; address steps only on a real write.
    always_ff @(posedge CLK) begin
        if (!reset) begin
            wr_addr   <= '0;
            remaining <= '0;
        end else if ((state == ST_IDLE) && start) begin
            wr_addr   <= base_addr;
            remaining <= (word_count == '0) ? {1'b1, {ADDR_W{1'b0}}} : {1'b0, word_count};
        end else if (wr_en) begin
            wr_addr   <= wr_addr + ADDR_W'(1);
            remaining <= remaining - CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Randomised scoreboard bench for imem_loader: the driver predicts writes and done pulses
// from the load rules, a negedge monitor pops and compares whatever the DUT presents.
module tb_imem_loader;
    import imem_pkg::*;

    logic                   CLK = 1'b0;
    logic                   reset = 1'b0;
    logic                   start = 1'b0;
    logic                   abort = 1'b0;
    logic                   byte_valid = 1'b0;
    logic [IMEM_ADDR_W-1:0] base_addr = '0;
    logic [IMEM_ADDR_W-1:0] word_count = '0;
    logic [7:0]             byte_in = '0;
    logic                   byte_ready, wr_en, busy, done;
    logic [IMEM_ADDR_W-1:0] wr_addr;
    logic [IMEM_DATA_W-1:0] wr_data;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct {
        logic [7:0]  addr;
        logic [23:0] data;
        int          cyc;
    } wr_exp_t;

    wr_exp_t    exp_wr[$];
    int         exp_done[$];
    logic [7:0] byte_src[$];
    wr_exp_t    mon_e;

    imem_loader dut (
        .CLK        (CLK),
        .reset      (reset),
        .start      (start),
        .base_addr  (base_addr),
        .word_count (word_count),
        .abort      (abort),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy),
        .done       (done)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Monitor: compares every write strobe and done pulse against the scoreboard.
    always @(negedge CLK) begin
        if (reset) begin
            if (wr_en) begin
                check("wr_en_with_done", {31'd0, done}, 32'd0);
                check("byte_ready_in_write", {31'd0, byte_ready}, 32'd0);
                if (exp_wr.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write actual_addr=0x%0h actual_data=0x%0h required=none",
                             wr_addr, wr_data);
                end else begin
                    mon_e = exp_wr.pop_front();
                    check("wr_addr", {24'd0, wr_addr}, {24'd0, mon_e.addr});
                    check("wr_data", {8'd0, wr_data}, {8'd0, mon_e.data});
                    check("wr_cycle", cyc, mon_e.cyc);
                end
            end
            if (done) begin
                check("busy_at_done", {31'd0, busy}, 32'd0);
                if (exp_done.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done actual_cycle=%0d required=none", cyc);
                end else begin
                    check("done_cycle", cyc, exp_done.pop_front());
                end
            end
        end
    end

    // mode: 0 = byte_valid always high, 1 = toggling, 2 = random. abort_at < 0 means no abort.
    task automatic load(input logic [7:0] base, input logic [7:0] cnt, input int mode,
                        input int abort_at, input bit mid_start);
        int          n_words = (cnt == 8'd0) ? 256 : int'(cnt);
        int          total   = n_words * 3;
        int          taken   = 0;
        int          nb      = 0;
        int          guard   = 0;
        int          last_wr = 0;
        bit          aborted = 0;
        bit          have    = 0;
        bit          tog     = 0;
        bit          v;
        logic [7:0]  b       = 8'd0;
        logic [7:0]  a       = base;
        logic [23:0] w       = 24'd0;

        @(posedge CLK); #1;
        start      = 1'b1;
        base_addr  = base;
        word_count = cnt;
        while (taken < total) begin
            @(posedge CLK); #1;
            start = 1'b0;
            abort = 1'b0;
            if (abort_at >= 0 && taken == abort_at && byte_ready) begin
                abort      = 1'b1;
                byte_valid = 1'b1;
                byte_in    = 8'hEE;
                exp_done.push_back(cyc + 1);
                aborted = 1;
                break;
            end
            if (mid_start && taken == 1) begin
                start      = 1'b1;
                base_addr  = ~base;
                word_count = 8'd1;
            end
            case (mode)
                0:       v = 1'b1;
                1:       begin tog = ~tog; v = tog; end
                default: v = 1'($urandom_range(0, 1));
            endcase
            if (!have) begin
                if (byte_src.size() > 0) b = byte_src.pop_front();
                else                     b = 8'($urandom);
                have = 1;
            end
            byte_valid = v;
            byte_in    = b;
            if (v && byte_ready) begin
                taken++;
                have = 0;
                w = {w[15:0], b};
                nb++;
                if (nb == 3) begin
                    exp_wr.push_back('{addr: a, data: w, cyc: cyc + 1});
                    last_wr = cyc + 1;
                    a  = a + 8'd1;
                    nb = 0;
                end
            end
            guard++;
            if (guard > 20 * total + 100) begin
                checks++;
                failures++;
                $display("FAIL byte_feed_timeout actual_taken=%0d required=%0d", taken, total);
                break;
            end
        end
        if (!aborted) exp_done.push_back(last_wr + 1);
        byte_src.delete();
        @(posedge CLK); #1;
        start      = 1'b0;
        abort      = 1'b0;
        byte_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (exp_done.size() > 0 && n < 40) begin
            @(negedge CLK);
            n++;
        end
        checks++;
        if (exp_done.size() > 0) begin
            failures++;
            $display("FAIL done_timeout actual_pending=%0d required=0", exp_done.size());
            exp_done.delete();
        end
        check("writes_drained", exp_wr.size(), 0);
        exp_wr.delete();
        @(posedge CLK); #1;
    endtask

    initial begin
        // Reset values
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst_byte_ready", {31'd0, byte_ready}, 32'd0);
        check("rst_wr_en", {31'd0, wr_en}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_wr_addr", {24'd0, wr_addr}, 32'd0);
        check("rst_wr_data", {8'd0, wr_data}, 32'd0);
        @(posedge CLK); #1;
        reset = 1'b1;
        @(posedge CLK); #1;

        // Directed load, then the same under toggling backpressure
        byte_src = '{8'h12, 8'h34, 8'h56, 8'hAB, 8'hCD, 8'hEF};
        load(8'h10, 8'd2, 0, -1, 0);
        wait_done();
        byte_src = '{8'h12, 8'h34, 8'h56, 8'hAB, 8'hCD, 8'hEF};
        load(8'h10, 8'd2, 1, -1, 1);
        wait_done();

        // Address wrap
        load(8'hFF, 8'd2, 2, -1, 0);
        wait_done();

        // Abort after two bytes of word 2, then a clean load
        load(8'h30, 8'd2, 0, 5, 0);
        wait_done();
        byte_src = '{8'hA1, 8'hB2, 8'hC3};
        load(8'h20, 8'd1, 0, -1, 0);
        wait_done();

        // Reset mid-load after one byte
        start = 1'b1; base_addr = 8'h40; word_count = 8'd3;
        @(posedge CLK); #1;
        start = 1'b0; byte_valid = 1'b1; byte_in = 8'h99;
        @(posedge CLK); #1;
        byte_valid = 1'b0; reset = 1'b0;
        @(posedge CLK); #1;
        reset = 1'b1;
        @(negedge CLK);
        check("midrst_byte_ready", {31'd0, byte_ready}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_done", {31'd0, done}, 32'd0);
        check("midrst_wr_addr", {24'd0, wr_addr}, 32'd0);
        check("midrst_wr_data", {8'd0, wr_data}, 32'd0);
        repeat (3) @(posedge CLK);
        #1;

        // Full 256-word load
        load(8'($urandom), 8'd0, 0, -1, 0);
        wait_done();

        // Random loads with random backpressure and occasional abort
        for (int i = 0; i < 12; i++) begin
            int c  = $urandom_range(1, 5);
            int ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, c * 3 - 1)) : -1;
            load(8'($urandom), 8'(c), $urandom_range(0, 2), ab, 1'($urandom_range(0, 1)));
            wait_done();
        end

        repeat (4) @(posedge CLK);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual_cycle=%0d required=finish", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "global timeout");
    end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter ADDR_W, default 8, instruction-memory address width (matches 8-bit PC).
REQ-002 Parameter DATA_W, default 24, instruction word width; SHALL be a multiple of 8.
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset; sampled on rising edge of CLK.
REQ-005 start  input  1  request a load; sampled only in IDLE.
REQ-006 base_addr  input  ADDR_W  first word address, captured on accepted start.
REQ-007 word_count  input  ADDR_W  words to load, captured on accepted start; 0 means 2^ADDR_W.
REQ-008 abort  input  1  terminate the load in progress.
REQ-009 byte_in  input  8  incoming program byte.
REQ-010 byte_valid  input  1  byte_in valid.
REQ-011 byte_ready  output  1  loader accepts a byte this cycle.
REQ-012 wr_en  output  1  one-cycle instruction-memory write strobe.
REQ-013 wr_addr  output  ADDR_W  write address.
REQ-014 wr_data  output  DATA_W  assembled instruction word.
REQ-015 busy  output  1  load in progress; also drives hold of the fetch PC.
REQ-016 done  output  1  one-cycle pulse after last word is written or on abort.

Function
REQ-017 FSM states: IDLE, COLLECT, WRITE, DONE.
REQ-018 IDLE: start=1 -> capture base_addr, word_count, clear byte index, go COLLECT.
REQ-019 COLLECT: byte_ready=1; a byte is accepted only when byte_valid && byte_ready in the same cycle.
REQ-020 Byte order big-endian: first accepted byte -> wr_data[DATA_W-1:DATA_W-8], last -> [7:0].
REQ-021 After the DATA_W/8-th accepted byte, next state WRITE; byte_ready=0 in WRITE, DONE, IDLE.
REQ-022 WRITE: wr_en=1 for exactly one cycle with wr_addr and wr_data stable; then address +1 modulo 2^ADDR_W, remaining count -1.
REQ-023 WRITE with remaining count 1 -> DONE; otherwise -> COLLECT.
REQ-024 DONE: done=1 for one cycle, then IDLE.
REQ-025 Latency: word write occurs the cycle after its last byte is accepted; done follows the last wr_en by one cycle.
REQ-026 wr_addr wraps from 2^ADDR_W-1 to 0 without error.
REQ-027 abort in COLLECT or WRITE -> DONE next cycle; no wr_en in that cycle; partially assembled word discarded; abort has priority over byte acceptance and write.
REQ-028 start while not IDLE ignored; abort in IDLE or DONE ignored.
REQ-029 busy=1 in COLLECT and WRITE, 0 in IDLE and DONE.
REQ-030 wr_en and done are never asserted in the same cycle.

Reset
REQ-031 reset=0 at a rising edge -> IDLE, byte_ready=0, wr_en=0, busy=0, done=0, wr_addr=0, wr_data=0, byte index=0, count=0.
REQ-032 Reset mid-load discards the partial word and produces no done pulse; reset overrides start and abort.

Structure
REQ-033 Shared package imem_pkg SHALL hold the loader state enum and the IMEM_ADDR_W=8 / IMEM_DATA_W=24 constants used by pc, instruction memory and loader.
REQ-034 One sub-module imem_byte_assembler (shift register + byte index, outputs word and word_full) is natural; FSM, address and count stay in imem_loader.

Verification
REQ-035 Load: base_addr=0x10, word_count=2, bytes 0x12,0x34,0x56,0xAB,0xCD,0xEF -> wr_en at 0x10 data 0x123456, at 0x11 data 0xABCDEF, then one done pulse, busy low.
REQ-036 Backpressure: byte_valid toggled 1/0 each cycle -> same two writes, no byte lost or duplicated; byte_ready=0 during WRITE cycles.
REQ-037 Wrap: base_addr=0xFF, word_count=2 -> writes at 0xFF then 0x00.
REQ-038 Abort after 2 bytes of word 2 -> no second write, done one cycle later, next start loads cleanly from byte index 0.
REQ-039 reset=0 asserted in COLLECT after 1 byte -> all outputs at reset values next cycle, no done; start during busy has no effect.
REQ-040 word_count=0 -> exactly 256 writes, addresses base..base+255 mod 256, then done.
